ultrasound_scan_scheduler: RTL and testbench

Sequencer that owns the `ultrasound_location_calculator` and decides when it runs. It merges periodic scan requests with one-shot manual requests, pulses the calculator's `calculate` input, and waits for `done` under a timeout with bounded retries. It publishes the last good 12-bit rover location to the path planner and display with valid, fresh and error flags.

---
 rtl/ultrasound_pkg.sv | 21 ++
 rtl/ultrasound_scan_scheduler_interval_timer.sv | 37 +++
 rtl/ultrasound_scan_scheduler.sv | 140 ++++++++++++++
 tb/tb_ultrasound_scan_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasound_pkg.sv
// Shared types and constants for the ultrasound scan scheduler.
`default_nettype none

package ultrasound_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    LATCH     = 2'd3
  } scan_state_t;

  localparam int LOC_W = 12;

  localparam int CLK_HZ                 = 27_000_000;
  localparam int PERIOD_CYCLES_DEFAULT  = CLK_HZ / 10;  // 100 ms
  localparam int TIMEOUT_CYCLES_DEFAULT = CLK_HZ / 20;  // 50 ms

endpackage

`default_nettype wire

// File: rtl/ultrasound_scan_scheduler_interval_timer.sv
// Loadable down-counter: clear wins, then load to MAX_COUNT-1, then decrement toward zero.
`default_nettype none

module interval_timer #(
  parameter int MAX_COUNT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic load,
  input  logic dec,
  output logic zero
);
  import ultrasound_pkg::*;

  localparam int W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [W-1:0] RELOAD = W'(MAX_COUNT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/ultrasound_scan_scheduler.sv
// Scan sequencer for the ultrasound location calculator: merges periodic and manual
// requests, launches the calculator, retries on timeout and publishes the last good location.
`default_nettype none

module ultrasound_scan_scheduler #(
  parameter int PERIOD_CYCLES  = ultrasound_pkg::PERIOD_CYCLES_DEFAULT,
  parameter int TIMEOUT_CYCLES = ultrasound_pkg::TIMEOUT_CYCLES_DEFAULT,
  parameter int MAX_RETRIES    = 2,
  parameter int LOC_W          = ultrasound_pkg::LOC_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             manual_request,
  input  logic             calc_done,
  input  logic [LOC_W-1:0] calc_location,
  output logic             calc_start,
  output logic [LOC_W-1:0] location,
  output logic             location_valid,
  output logic             new_location,
  output logic             timeout_error,
  output logic             busy
);
  import ultrasound_pkg::*;

  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  scan_state_t   state;
  logic          periodic_pending;
  logic          manual_pending;
  logic [RW-1:0] retries;

  logic period_zero;
  logic period_tick;
  logic timeout_zero;

  assign period_tick = enable && period_zero;

  // Free-running in every state so scan length never stretches the period.
  interval_timer #(.MAX_COUNT(PERIOD_CYCLES)) u_period_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (!enable),
    .load    (period_tick),
    .dec     (enable),
    .zero    (period_zero)
  );

  interval_timer #(.MAX_COUNT(TIMEOUT_CYCLES)) u_timeout_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (1'b0),
    .load    (state == START),
    .dec     (state == WAIT_DONE),
    .zero    (timeout_zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      periodic_pending <= 1'b0;
      manual_pending   <= 1'b0;
      retries          <= '0;
      calc_start       <= 1'b0;
      location         <= '0;
      location_valid   <= 1'b0;
      new_location     <= 1'b0;
      timeout_error    <= 1'b0;
      busy             <= 1'b0;
    end else begin
      calc_start   <= 1'b0;
      new_location <= 1'b0;

      if (!enable) begin
        periodic_pending <= 1'b0;
      end else if (period_zero) begin
        periodic_pending <= 1'b1;
      end

      if ((state != IDLE) && manual_request) begin
        manual_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          // One launch serves every request coalesced so far; a tick landing now still counts.
          if (periodic_pending || manual_pending || manual_request) begin
            state          <= START;
            calc_start     <= 1'b1;
            busy           <= 1'b1;
            manual_pending <= 1'b0;
            if (!period_tick) begin
              periodic_pending <= 1'b0;
            end
          end
        end

        START: begin
          state <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (calc_done) begin
            location       <= calc_location;
            location_valid <= 1'b1;
            new_location   <= 1'b1;
            timeout_error  <= 1'b0;
            state          <= LATCH;
          end else if (timeout_zero) begin
            if (int'(retries) < MAX_RETRIES) begin
              retries    <= retries + 1'b1;
              state      <= START;
              calc_start <= 1'b1;
            end else begin
              timeout_error  <= 1'b1;
              location_valid <= 1'b0;
              retries        <= '0;
              state          <= IDLE;
              busy           <= 1'b0;
            end
          end
        end

        LATCH: begin
          retries <= '0;
          state   <= IDLE;
          busy    <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ultrasound_scan_scheduler.sv
// Directed bench with a calculator model and a location scoreboard.
`default_nettype none

module tb_ultrasound_scan_scheduler;
  import ultrasound_pkg::*;

  localparam int PERIOD  = 100;
  localparam int TIMEOUT = 20;
  localparam int RETRIES = 2;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             manual_request = 1'b0;
  logic             calc_done = 1'b0;
  logic [LOC_W-1:0] calc_location = '0;
  logic             calc_start;
  logic [LOC_W-1:0] location;
  logic             location_valid;
  logic             new_location;
  logic             timeout_error;
  logic             busy;

  ultrasound_scan_scheduler #(
    .PERIOD_CYCLES  (PERIOD),
    .TIMEOUT_CYCLES (TIMEOUT),
    .MAX_RETRIES    (RETRIES),
    .LOC_W          (LOC_W)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .manual_request (manual_request),
    .calc_done      (calc_done),
    .calc_location  (calc_location),
    .calc_start     (calc_start),
    .location       (location),
    .location_valid (location_valid),
    .new_location   (new_location),
    .timeout_error  (timeout_error),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cnt = 0;
  int newloc_cnt = 0;
  int start_cyc[$];
  logic [LOC_W-1:0] exp_q[$];

  int               model_delay = 15;
  logic [LOC_W-1:0] model_loc = 12'h3A5;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    start_cnt  = 0;
    newloc_cnt = 0;
    start_cyc.delete();
  endtask

  task automatic manual_pulse();
    @(negedge clock);
    manual_request = 1'b1;
    @(negedge clock);
    manual_request = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: counts launches and scores every published location.
  always @(negedge clock) begin
    if (reset_n) begin
      if (calc_start) begin
        start_cnt++;
        start_cyc.push_back(cyc);
      end
      if (new_location) begin
        newloc_cnt++;
        if (exp_q.size() == 0) check("sb_unexpected_new_location", 32'd1, 32'd0);
        else check("sb_location", 32'(location), 32'(exp_q.pop_front()));
        check("sb_valid", 32'(location_valid), 32'd1);
      end
    end
  end

  // Calculator model: after model_delay cycles present a result for one cycle.
  initial begin : calc_model
    int d;
    forever begin
      @(negedge clock);
      if (calc_start && (model_delay >= 0)) begin
        d = model_delay;
        repeat (d) @(posedge clock);
        #1;
        calc_done     = 1'b1;
        calc_location = model_loc;
        exp_q.push_back(model_loc);
        model_loc     = model_loc + 1'b1;
        @(posedge clock);
        #1;
        calc_done     = 1'b0;
        calc_location = '0;
      end
    end
  end

  initial begin : stimulus
    int t0;

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_calc_start", 32'(calc_start), 32'd0);
    check("rst_location", 32'(location), 32'd0);
    check("rst_valid", 32'(location_valid), 32'd0);
    check("rst_new_location", 32'(new_location), 32'd0);
    check("rst_timeout", 32'(timeout_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    idle_cycles(3);

    // Single manual scan
    clear_counts();
    model_delay = 15;
    model_loc   = 12'h3A5;
    @(negedge clock);
    t0 = cyc;
    manual_request = 1'b1;
    @(negedge clock);
    manual_request = 1'b0;
    idle_cycles(25);
    check("man_start_cnt", 32'(start_cnt), 32'd1);
    if (start_cyc.size() > 0) check("man_start_latency", 32'(start_cyc[0] - t0), 32'd1);
    else check("man_start_seen", 32'd0, 32'd1);
    check("man_newloc_cnt", 32'(newloc_cnt), 32'd1);
    check("man_location", 32'(location), 32'h3A5);
    check("man_valid", 32'(location_valid), 32'd1);
    check("man_busy", 32'(busy), 32'd0);

    // Periodic scanning
    clear_counts();
    model_delay = 10;
    model_loc   = 12'h1C4;
    @(negedge clock);
    t0 = cyc;
    enable = 1'b1;
    idle_cycles(230);
    enable = 1'b0;
    idle_cycles(20);
    check("per_start_cnt", 32'(start_cnt), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < start_cyc.size()) check($sformatf("per_start_%0d", i), 32'(start_cyc[i] - t0), 32'(2 + i * PERIOD));
      else check($sformatf("per_start_%0d_seen", i), 32'd0, 32'd1);
    end
    check("per_newloc_cnt", 32'(newloc_cnt), 32'd3);
    check("per_location", 32'(location), 32'h1C6);

    // Timeout with retries, then recovery
    clear_counts();
    model_delay = -1;
    manual_pulse();
    idle_cycles(3 * (TIMEOUT + 1) + 10);
    check("tmo_start_cnt", 32'(start_cnt), 32'd3);
    for (int i = 1; i < 3; i++) begin
      if (i < start_cyc.size()) check($sformatf("tmo_spacing_%0d", i), 32'(start_cyc[i] - start_cyc[i-1]), 32'(TIMEOUT + 1));
      else check($sformatf("tmo_spacing_%0d_seen", i), 32'd0, 32'd1);
    end
    check("tmo_error", 32'(timeout_error), 32'd1);
    check("tmo_valid", 32'(location_valid), 32'd0);
    check("tmo_location_hold", 32'(location), 32'h1C6);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_newloc_cnt", 32'(newloc_cnt), 32'd0);
    clear_counts();
    model_delay = 5;
    model_loc   = 12'h2B7;
    manual_pulse();
    idle_cycles(15);
    check("rec_error_cleared", 32'(timeout_error), 32'd0);
    check("rec_valid", 32'(location_valid), 32'd1);
    check("rec_location", 32'(location), 32'h2B7);

    // Done coincides with timeout counter reaching zero
    clear_counts();
    model_delay = TIMEOUT;
    model_loc   = 12'h0F0;
    manual_pulse();
    idle_cycles(40);
    check("edge_start_cnt", 32'(start_cnt), 32'd1);
    check("edge_newloc_cnt", 32'(newloc_cnt), 32'd1);
    check("edge_location", 32'(location), 32'h0F0);
    check("edge_timeout", 32'(timeout_error), 32'd0);

    // Manual requests during a busy scan coalesce to one follow-on
    clear_counts();
    model_delay = 15;
    model_loc   = 12'h155;
    manual_pulse();
    idle_cycles(3);
    check("coal_busy", 32'(busy), 32'd1);
    repeat (5) manual_pulse();
    idle_cycles(60);
    check("coal_start_cnt", 32'(start_cnt), 32'd2);
    check("coal_newloc_cnt", 32'(newloc_cnt), 32'd2);
    check("coal_location", 32'(location), 32'h156);
    check("coal_busy_after", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of WAIT_DONE
    clear_counts();
    model_delay = -1;
    manual_pulse();
    idle_cycles(8);
    check("arst_busy_before", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_location", 32'(location), 32'd0);
    check("arst_valid", 32'(location_valid), 32'd0);
    check("arst_timeout", 32'(timeout_error), 32'd0);
    check("arst_new_location", 32'(new_location), 32'd0);
    check("arst_calc_start", 32'(calc_start), 32'd0);
    idle_cycles(3);
    reset_n = 1'b1;
    clear_counts();
    idle_cycles(30);
    check("arst_no_start", 32'(start_cnt), 32'd0);
    model_delay = 5;
    model_loc   = 12'h3C3;
    manual_pulse();
    idle_cycles(15);
    check("arst_new_start", 32'(start_cnt), 32'd1);
    check("arst_new_location_val", 32'(location), 32'h3C3);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
